// File: rtl/lvds_lane_bridge.sv
// rtl/lvds_lane_bridge.sv - word FIFOs plus multi-lane serialiser/deserialiser with start-of-frame framing
module lvds_lane_bridge #(
    parameter int WORD_W    = 32,
    parameter int LANES     = 4,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int RX_MARGIN = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WORD_W-1:0] enq_tx,
    input  logic              EN_enq_tx,
    output logic              RDY_enq_tx,
    output logic [WORD_W-1:0] deq_rx,
    input  logic              EN_deq_rx,
    output logic              RDY_deq_rx,
    output logic [LANES-1:0]  tx_data,
    output logic              tx_sof,
    input  logic              RDY_from_recv,
    input  logic [LANES-1:0]  rx_data,
    input  logic              rx_sof,
    output logic              RDY_for_trans,
    output logic [1:0]        err,
    output logic [7:0]        led
);

    localparam int BEATS = WORD_W / LANES;
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int TAW   = $clog2(TX_DEPTH);
    localparam int RAW   = $clog2(RX_DEPTH);

    localparam logic [BCW-1:0] BEATS_C   = BCW'(BEATS);
    localparam logic [TAW:0]   TX_FULL   = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0]   RX_FULL   = (RAW+1)'(RX_DEPTH);
    localparam logic [RAW:0]   RX_MARG_C = (RAW+1)'(RX_MARGIN);

    typedef enum logic {T_IDLE, T_SEND} tx_state_t;
    typedef enum logic {R_IDLE, R_RECV} rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [WORD_W-1:0] tx_mem [TX_DEPTH];
    logic [TAW-1:0]    tx_wr_ptr;
    logic [TAW-1:0]    tx_rd_ptr;
    logic [TAW:0]      tx_count;
    logic              tx_push;
    logic              tx_pop;
    logic [WORD_W-1:0] tx_head;

    assign RDY_enq_tx = (tx_count != TX_FULL);
    assign tx_push    = EN_enq_tx && RDY_enq_tx;
    assign tx_head    = tx_mem[tx_rd_ptr];

    always_ff @(posedge CLK) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= enq_tx;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TAW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TAW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (TAW+1)'(1);
                2'b01:   tx_count <= tx_count - (TAW+1)'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t         tx_state;
    tx_state_t         tx_state_nxt;
    logic [BCW-1:0]    tx_beat;
    logic [WORD_W-1:0] tx_shreg;
    logic              tx_can_start;
    logic              tx_last;
    logic              tx_shift;

    assign tx_can_start = (tx_count != '0) && RDY_from_recv;
    // tx_beat counts beats already placed on the lanes, so BEATS means the last one is showing
    assign tx_last      = (tx_state == T_SEND) && (tx_beat == BEATS_C);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tx_state <= T_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            T_IDLE: if (tx_can_start) tx_state_nxt = T_SEND;
            T_SEND: if (tx_last && !tx_can_start) tx_state_nxt = T_IDLE;
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    always_comb begin
        tx_pop   = 1'b0;
        tx_shift = 1'b0;
        case (tx_state)
            T_IDLE: tx_pop = tx_can_start;
            T_SEND: begin
                tx_pop   = tx_last && tx_can_start;
                tx_shift = !tx_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tx_data  <= '0;
            tx_sof   <= 1'b0;
            tx_beat  <= '0;
            tx_shreg <= '0;
        end else if (tx_pop) begin
            tx_data  <= tx_head[WORD_W-1 -: LANES];
            tx_sof   <= 1'b1;
            tx_shreg <= tx_head << LANES;
            tx_beat  <= BCW'(1);
        end else if (tx_shift) begin
            tx_data  <= tx_shreg[WORD_W-1 -: LANES];
            tx_sof   <= 1'b0;
            tx_shreg <= tx_shreg << LANES;
            tx_beat  <= tx_beat + BCW'(1);
        end else begin
            tx_data  <= '0;
            tx_sof   <= 1'b0;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t         rx_state;
    rx_state_t         rx_state_nxt;
    logic [BCW-1:0]    rx_beat;
    logic [WORD_W-1:0] rx_shreg;
    logic [WORD_W-1:0] rx_ext;
    logic [WORD_W-1:0] rx_word_nxt;
    logic [BCW-1:0]    rx_beat_nxt;
    logic              rx_valid;
    logic              rx_done;
    logic              rx_full;
    logic              rx_push;
    logic              rx_ovf;
    logic              rx_frame_err;

    always_comb begin
        rx_ext              = '0;
        rx_ext[LANES-1:0]   = rx_data;
    end

    // a sof beat always restarts assembly, discarding any partial word
    assign rx_valid    = rx_sof || (rx_state == R_RECV);
    assign rx_word_nxt = rx_sof ? rx_ext : ((rx_shreg << LANES) | rx_ext);
    assign rx_beat_nxt = rx_sof ? BCW'(1) : (rx_beat + BCW'(1));
    assign rx_done     = rx_valid && (rx_beat_nxt == BEATS_C);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            R_IDLE: if (rx_sof && !rx_done) rx_state_nxt = R_RECV;
            R_RECV: if (rx_done) rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        rx_push      = 1'b0;
        rx_ovf       = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state)
            R_IDLE: begin
                rx_push = rx_done && !rx_full;
                rx_ovf  = rx_done && rx_full;
            end
            R_RECV: begin
                rx_push      = rx_done && !rx_full;
                rx_ovf       = rx_done && rx_full;
                rx_frame_err = rx_sof;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_shreg <= '0;
            rx_beat  <= '0;
        end else if (rx_valid) begin
            rx_shreg <= rx_word_nxt;
            rx_beat  <= rx_beat_nxt;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [WORD_W-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]    rx_wr_ptr;
    logic [RAW-1:0]    rx_rd_ptr;
    logic [RAW:0]      rx_count;
    logic              rx_pop;

    assign rx_full    = (rx_count == RX_FULL);
    assign RDY_deq_rx = (rx_count != '0);
    assign rx_pop     = EN_deq_rx && RDY_deq_rx;
    assign deq_rx     = rx_mem[rx_rd_ptr];

    always_ff @(posedge CLK) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_word_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RAW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RAW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (RAW+1)'(1);
                2'b01:   rx_count <= rx_count - (RAW+1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err           <= '0;
            led           <= '0;
            RDY_for_trans <= 1'b0;
        end else begin
            err[0]        <= err[0] | rx_frame_err;
            err[1]        <= err[1] | rx_ovf;
            RDY_for_trans <= (RX_FULL - rx_count) >= RX_MARG_C;
            if (rx_push) begin
                led <= led + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lvds_lane_bridge.sv
// tb/tb_lvds_lane_bridge.sv - directed self-checking bench for lvds_lane_bridge
module tb_lvds_lane_bridge;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] enq_tx;
    logic        EN_enq_tx;
    logic        RDY_enq_tx;
    logic [31:0] deq_rx;
    logic        EN_deq_rx;
    logic        RDY_deq_rx;
    logic [3:0]  tx_data;
    logic        tx_sof;
    logic        RDY_from_recv;
    logic [3:0]  rx_data;
    logic        rx_sof;
    logic        RDY_for_trans;
    logic [1:0]  err;
    logic [7:0]  led;

    logic        loop_en;
    logic [3:0]  inj_data;
    logic        inj_sof;

    int n_checks = 0;
    int n_errors = 0;
    int exp_led  = 0;

    assign rx_data = loop_en ? tx_data : inj_data;
    assign rx_sof  = loop_en ? tx_sof  : inj_sof;

    always #5 CLK = ~CLK;

    lvds_lane_bridge #(
        .WORD_W(32), .LANES(4), .TX_DEPTH(8), .RX_DEPTH(8), .RX_MARGIN(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .enq_tx(enq_tx), .EN_enq_tx(EN_enq_tx), .RDY_enq_tx(RDY_enq_tx),
        .deq_rx(deq_rx), .EN_deq_rx(EN_deq_rx), .RDY_deq_rx(RDY_deq_rx),
        .tx_data(tx_data), .tx_sof(tx_sof), .RDY_from_recv(RDY_from_recv),
        .rx_data(rx_data), .rx_sof(rx_sof), .RDY_for_trans(RDY_for_trans),
        .err(err), .led(led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input logic [31:0] w);
        enq_tx    = w;
        EN_enq_tx = 1'b1;
        step();
        EN_enq_tx = 1'b0;
    endtask

    // first beat must already be on the lanes; returns with the last beat showing
    task automatic expect_beats(input logic [31:0] w, input string tag, input int drop_at);
        for (int i = 0; i < 8; i++) begin
            if (i == drop_at) RDY_from_recv = 1'b0;
            check(tag, {27'd0, tx_sof, tx_data}, {27'd0, (i == 0), w[31-4*i -: 4]});
            if (i != 7) step();
        end
    endtask

    task automatic deq_check(input logic [31:0] exp, input string tag);
        check({tag, "_rdy"}, {31'd0, RDY_deq_rx}, 32'd1);
        check(tag, deq_rx, exp);
        EN_deq_rx = 1'b1;
        step();
        EN_deq_rx = 1'b0;
    endtask

    task automatic rx_beat(input logic sof, input logic [3:0] d);
        inj_sof  = sof;
        inj_data = d;
        step();
    endtask

    task automatic send_rx_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) rx_beat(i == 0, w[31-4*i -: 4]);
        rx_beat(1'b0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; enq_tx = '0; EN_enq_tx = 1'b0; EN_deq_rx = 1'b0;
        RDY_from_recv = 1'b0; loop_en = 1'b1; inj_data = '0; inj_sof = 1'b0;
        step(); step();

        check("rst_tx", {27'd0, tx_sof, tx_data}, 32'd0);
        check("rst_rdy_for_trans", {31'd0, RDY_for_trans}, 32'd0);
        check("rst_err", {30'd0, err}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_rdy_enq", {31'd0, RDY_enq_tx}, 32'd1);
        check("rst_rdy_deq", {31'd0, RDY_deq_rx}, 32'd0);
        RST_N = 1'b1;
        step();
        check("rdy_for_trans_after_rst", {31'd0, RDY_for_trans}, 32'd1);

        // single word loopback
        RDY_from_recv = 1'b1;
        enq(32'hDEADBEEF);
        check("t1_latency", {31'd0, tx_sof}, 32'd0);
        step();
        expect_beats(32'hDEADBEEF, "t1_beat", -1);
        check("t1_not_yet", {31'd0, RDY_deq_rx}, 32'd0);
        step();
        exp_led = 1;
        check("t1_led", {24'd0, led}, exp_led);
        deq_check(32'hDEADBEEF, "t1_deq");
        check("t1_empty", {31'd0, RDY_deq_rx}, 32'd0);

        // three words back to back, no gaps
        RDY_from_recv = 1'b0;
        enq(32'hA1B2C3D4); enq(32'h0F1E2D3C); enq(32'h55AA33CC);
        RDY_from_recv = 1'b1;
        step();
        expect_beats(32'hA1B2C3D4, "t2_w0", -1); step();
        expect_beats(32'h0F1E2D3C, "t2_w1", -1); step();
        expect_beats(32'h55AA33CC, "t2_w2", -1); step();
        check("t2_idle", {27'd0, tx_sof, tx_data}, 32'd0);
        exp_led = 4;
        check("t2_led", {24'd0, led}, exp_led);
        deq_check(32'hA1B2C3D4, "t2_deq0");
        deq_check(32'h0F1E2D3C, "t2_deq1");
        deq_check(32'h55AA33CC, "t2_deq2");

        // ready drops mid-word: word completes, next is held
        RDY_from_recv = 1'b0;
        enq(32'h13579BDF); enq(32'h2468ACE0);
        RDY_from_recv = 1'b1;
        step();
        expect_beats(32'h13579BDF, "t3_w0", 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_held", {27'd0, tx_sof, tx_data}, 32'd0);
        end
        RDY_from_recv = 1'b1;
        step();
        expect_beats(32'h2468ACE0, "t3_w1", -1);
        step();
        exp_led = 6;
        check("t3_led", {24'd0, led}, exp_led);
        deq_check(32'h13579BDF, "t3_deq0");
        deq_check(32'h2468ACE0, "t3_deq1");

        // sof injected at beat 5 of a frame
        loop_en = 1'b0;
        rx_beat(1'b1, 4'hA); rx_beat(1'b0, 4'hB); rx_beat(1'b0, 4'hC);
        rx_beat(1'b0, 4'hD); rx_beat(1'b0, 4'hE);
        check("t4_err_before", {30'd0, err}, 32'd0);
        send_rx_word(32'h12345678);
        check("t4_err", {30'd0, err}, 32'd1);
        exp_led = 7;
        check("t4_led", {24'd0, led}, exp_led);
        deq_check(32'h12345678, "t4_deq");
        check("t4_partial_dropped", {31'd0, RDY_deq_rx}, 32'd0);

        // fill RX FIFO, then overflow
        for (int k = 0; k < 8; k++) begin
            send_rx_word(32'hC0DE0000 + k);
            check("t5_rdy_for_trans", {31'd0, RDY_for_trans}, {31'd0, (k < 4)});
        end
        send_rx_word(32'hBAD0BAD0);
        check("t5_err", {30'd0, err}, 32'd3);
        exp_led = 15;
        check("t5_led", {24'd0, led}, exp_led);
        for (int k = 0; k < 8; k++) deq_check(32'hC0DE0000 + k, "t5_deq");
        check("t5_drained", {31'd0, RDY_deq_rx}, 32'd0);

        // reset mid-frame with a word still queued
        loop_en = 1'b1;
        RDY_from_recv = 1'b1;
        enq(32'h89ABCDEF); enq(32'h76543210);
        step(); step();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        check("t6_tx", {27'd0, tx_sof, tx_data}, 32'd0);
        check("t6_rdy_for_trans", {31'd0, RDY_for_trans}, 32'd0);
        check("t6_err", {30'd0, err}, 32'd0);
        check("t6_led", {24'd0, led}, 32'd0);
        check("t6_rdy_deq", {31'd0, RDY_deq_rx}, 32'd0);
        check("t6_rdy_enq", {31'd0, RDY_enq_tx}, 32'd1);
        step();
        check("t6_txfifo_empty0", {27'd0, tx_sof, tx_data}, 32'd0);
        step();
        check("t6_txfifo_empty1", {27'd0, tx_sof, tx_data}, 32'd0);
        enq(32'hCAFEF00D);
        step();
        expect_beats(32'hCAFEF00D, "t6_beat", -1);
        step();
        check("t6_led_after", {24'd0, led}, 32'd1);
        deq_check(32'hCAFEF00D, "t6_deq");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
